// File: rtl/pipe_rca_if.sv
// rtl/pipe_rca_if.sv - operand/result handshake bundle for the pipelined ripple-carry adder
interface pipe_rca_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, co, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, co, ovf
    );
endinterface

// File: rtl/pipe_rca.sv
// rtl/pipe_rca.sv - WIDTH-bit adder split into STAGES chunk adders with registered carries
// Stage k keeps the finished low sum bits and only the operand bits above its own chunk.
module pipe_rca #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic     clk,
    input  logic     rst,
    pipe_rca_if.slave bus
);
    localparam int CW = WIDTH / STAGES;

    logic w_adv;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_st
            localparam int REM = WIDTH - (k + 1) * CW;

            logic                  w_vin;
            logic                  w_cin;
            logic [CW-1:0]         w_ain;
            logic [CW-1:0]         w_bin;
            logic [CW:0]           w_add;
            logic [(k+1)*CW-1:0]   w_sum_n;
            logic                  r_valid;
            logic                  r_c;
            logic [(k+1)*CW-1:0]   r_sum;

            if (k == 0) begin : g_src
                assign w_vin   = bus.in_valid;
                assign w_cin   = bus.cin;
                assign w_ain   = bus.a[CW-1:0];
                assign w_bin   = bus.b[CW-1:0];
                assign w_sum_n = w_add[CW-1:0];
            end else begin : g_src
                assign w_vin   = g_st[k-1].r_valid;
                assign w_cin   = g_st[k-1].r_c;
                assign w_ain   = g_st[k-1].g_skew.r_a[CW-1:0];
                assign w_bin   = g_st[k-1].g_skew.r_b[CW-1:0];
                assign w_sum_n = {w_add[CW-1:0], g_st[k-1].r_sum};
            end

            assign w_add = {1'b0, w_ain} + {1'b0, w_bin} + {{CW{1'b0}}, w_cin};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_c     <= 1'b0;
                    r_sum   <= '0;
                end else if (w_adv) begin
                    r_valid <= w_vin;
                    r_c     <= w_add[CW];
                    r_sum   <= w_sum_n;
                end
            end

            // Skew: the not-yet-added upper operand bits, current chunk at the bottom.
            if (k < STAGES - 1) begin : g_skew
                logic [REM-1:0] r_a;
                logic [REM-1:0] r_b;
                logic [REM-1:0] w_a_up;
                logic [REM-1:0] w_b_up;

                if (k == 0) begin : g_up
                    assign w_a_up = bus.a[WIDTH-1:CW];
                    assign w_b_up = bus.b[WIDTH-1:CW];
                end else begin : g_up
                    assign w_a_up = g_st[k-1].g_skew.r_a[REM+CW-1:CW];
                    assign w_b_up = g_st[k-1].g_skew.r_b[REM+CW-1:CW];
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else if (w_adv) begin
                        r_a <= w_a_up;
                        r_b <= w_b_up;
                    end
                end
            end

            // Carry into the MSB recovered as a^b^sum at that bit, so it works for any CW.
            if (k == STAGES - 1) begin : g_last
                logic r_ovf;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_ovf <= 1'b0;
                    end else if (w_adv) begin
                        r_ovf <= w_ain[CW-1] ^ w_bin[CW-1] ^ w_add[CW-1] ^ w_add[CW];
                    end
                end
            end
        end
    endgenerate

    assign w_adv         = !g_st[STAGES-1].r_valid || bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = g_st[STAGES-1].r_valid;
    assign bus.sum       = g_st[STAGES-1].r_sum;
    assign bus.co        = g_st[STAGES-1].r_c;
    assign bus.ovf       = g_st[STAGES-1].g_last.r_ovf;
endmodule

// File: tb/tb_pipe_rca.sv
// tb/tb_pipe_rca.sv - drives STAGES=1/4/16 adders from one stimulus stream, scored against a+b+cin
module tb_pipe_rca;
    logic        clk;
    logic        rst;
    logic        t_in_valid;
    logic        t_out_ready;
    logic [15:0] t_a;
    logic [15:0] t_b;
    logic        t_cin;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // {co, ovf, sum} from plain integer arithmetic and sign rules
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] s;
        logic        v;
        s = {1'b0, x} + {1'b0, y} + {16'd0, c};
        v = (x[15] == y[15]) && (s[15] != x[15]);
        return {s[16], v, s[15:0]};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            localparam int ST = (g == 0) ? 1 : ((g == 1) ? 4 : 16);

            pipe_rca_if #(.WIDTH(16)) bus ();

            assign bus.in_valid  = t_in_valid;
            assign bus.a         = t_a;
            assign bus.b         = t_b;
            assign bus.cin       = t_cin;
            assign bus.out_ready = t_out_ready;

            pipe_rca #(.WIDTH(16), .STAGES(ST)) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );

            logic [17:0] q[$];
            logic [17:0] held;
            logic        held_v;
            logic [17:0] expv;

            always @(negedge clk) begin
                if (rst) begin
                    q.delete();
                    held_v <= 1'b0;
                end else begin
                    if (held_v)
                        chk($sformatf("hold_s%0d", ST), {13'd0, bus.out_valid, bus.co, bus.ovf, bus.sum},
                            {13'd0, 1'b1, held});
                    held_v <= bus.out_valid && !t_out_ready;
                    held   <= {bus.co, bus.ovf, bus.sum};
                    if (bus.out_valid && t_out_ready) begin
                        chk($sformatf("have_exp_s%0d", ST), {31'd0, q.size() > 0}, 32'd1);
                        if (q.size() > 0) begin
                            expv = q.pop_front();
                            chk($sformatf("result_s%0d", ST), {14'd0, bus.co, bus.ovf, bus.sum}, {14'd0, expv});
                        end
                    end
                    if (t_in_valid && bus.in_ready)
                        q.push_back(model(t_a, t_b, t_cin));
                end
            end
        end
    endgenerate

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'hFFFF;
            1:       return 16'h8000;
            2:       return 16'h7FFF;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    int lat0, lat1, lat2, cnt, run, maxrun;
    logic [15:0] cap_sum;
    logic        cap_co, cap_ovf;
    logic [15:0] sa[6];
    logic [15:0] sb[6];
    logic        sc[6];

    initial begin
        rst = 1'b1; t_in_valid = 1'b0; t_out_ready = 1'b1;
        t_a = '0; t_b = '0; t_cin = 1'b0;
        repeat (3) step();
        chk("rst_out_valid", {31'd0, g_dut[1].bus.out_valid}, 32'd0);
        chk("rst_sum", {16'd0, g_dut[1].bus.sum}, 32'd0);
        chk("rst_co_ovf", {30'd0, g_dut[1].bus.co, g_dut[1].bus.ovf}, 32'd0);
        rst = 1'b0;
        step();
        chk("rst_in_ready", {29'd0, g_dut[0].bus.in_ready, g_dut[1].bus.in_ready, g_dut[2].bus.in_ready}, 32'd7);

        // full ripple, with latency measured on every depth
        t_in_valid = 1'b1; t_a = 16'hFFFF; t_b = 16'h0001; t_cin = 1'b0;
        step();
        t_in_valid = 1'b0; t_a = 16'($urandom); t_b = 16'($urandom); t_cin = 1'b1;
        lat0 = -1; lat1 = -1; lat2 = -1;
        cap_sum = '1; cap_co = 1'b0; cap_ovf = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (g_dut[0].bus.out_valid && lat0 < 0) lat0 = c;
            if (g_dut[1].bus.out_valid && lat1 < 0) begin
                lat1 = c; cap_sum = g_dut[1].bus.sum; cap_co = g_dut[1].bus.co; cap_ovf = g_dut[1].bus.ovf;
            end
            if (g_dut[2].bus.out_valid && lat2 < 0) lat2 = c;
            step();
        end
        chk("lat_s1", lat0, 0);
        chk("lat_s4", lat1, 3);
        chk("lat_s16", lat2, 15);
        chk("ripple_sum", {16'd0, cap_sum}, 32'h0000);
        chk("ripple_co_ovf", {30'd0, cap_co, cap_ovf}, 32'd2);

        // signed overflow pair, back to back
        t_in_valid = 1'b1; t_a = 16'h7FFF; t_b = 16'h0001; t_cin = 1'b0;
        step();
        t_a = 16'h8000; t_b = 16'h8000; t_cin = 1'b1;
        step();
        t_in_valid = 1'b0;
        repeat (20) step();

        // streaming: six back-to-back pairs must come out on six consecutive cycles
        sa[0] = 16'h00F0; sb[0] = 16'h0010; sc[0] = 1'b1;
        sa[1] = 16'hFFFF; sb[1] = 16'hFFFF; sc[1] = 1'b1;
        for (int i = 2; i < 6; i++) begin
            sa[i] = 16'($urandom); sb[i] = 16'($urandom); sc[i] = 1'($urandom);
        end
        cnt = 0; run = 0; maxrun = 0;
        for (int c = 0; c < 30; c++) begin
            if (c < 6) begin
                t_in_valid = 1'b1; t_a = sa[c]; t_b = sb[c]; t_cin = sc[c];
            end else begin
                t_in_valid = 1'b0;
            end
            step();
            if (g_dut[1].bus.out_valid) begin
                cnt++; run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        chk("stream_count", cnt, 6);
        chk("stream_run", maxrun, 6);

        // backpressure with the input still offering data
        t_out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            t_in_valid = 1'b1; t_a = pick(); t_b = pick(); t_cin = 1'($urandom);
            step();
        end
        chk("bp_ready_s4", {31'd0, g_dut[1].bus.in_ready}, 32'd0);
        chk("bp_ready_s1", {31'd0, g_dut[0].bus.in_ready}, 32'd0);
        chk("bp_valid_s4", {31'd0, g_dut[1].bus.out_valid}, 32'd1);
        t_out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            t_a = pick(); t_b = pick(); t_cin = 1'($urandom);
            step();
        end
        t_in_valid = 1'b0;
        repeat (24) step();
        chk("bp_drain_s4", g_dut[1].q.size(), 0);

        // reset with results in flight
        for (int c = 0; c < 3; c++) begin
            t_in_valid = 1'b1; t_a = pick(); t_b = pick(); t_cin = 1'($urandom);
            step();
        end
        t_in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_valid", {29'd0, g_dut[0].bus.out_valid, g_dut[1].bus.out_valid, g_dut[2].bus.out_valid},
            32'd0);
        chk("midrst_sum_s1", {16'd0, g_dut[0].bus.sum}, 32'd0);
        step();
        step();
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 25; c++) begin
            step();
            if (g_dut[0].bus.out_valid || g_dut[1].bus.out_valid || g_dut[2].bus.out_valid) cnt++;
        end
        chk("postrst_stale", cnt, 0);

        // randomized traffic with random backpressure
        for (int c = 0; c < 3000; c++) begin
            t_in_valid  = ($urandom_range(0, 3) != 0);
            t_out_ready = ($urandom_range(0, 9) < 7);
            t_a   = pick();
            t_b   = pick();
            t_cin = 1'($urandom);
            step();
        end
        t_in_valid  = 1'b0;
        t_out_ready = 1'b1;
        repeat (40) step();
        chk("drain_s1", g_dut[0].q.size(), 0);
        chk("drain_s4", g_dut[1].q.size(), 0);
        chk("drain_s16", g_dut[2].q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_rca.md
# pipe_rca

Parametrised, pipelined ripple-carry adder, successor to the 4-bit combinational `rca`. It splits a WIDTH-bit add into STAGES chunk adders, one per pipeline stage, with the carry registered between stages. It accepts one operand pair per cycle under a valid/ready handshake and supports output backpressure. It is the datapath adder for wide accumulate/compare paths where a full-width ripple does not close timing.

## Interface
- `WIDTH`, 16: operand and sum width; must be a multiple of STAGES.
- `STAGES`, 4: pipeline depth and chunk count, 1..WIDTH; chunk width `CW = WIDTH/STAGES`.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous and active-high; clears all valid state.
- `in_valid`  in  1  operand pair present on `a`/`b`/`cin`.
- `in_ready`  out  1  pipeline can accept this cycle.
- `a`  in  WIDTH  operand A, unsigned or two's complement.
- `b`  in  WIDTH  operand B.
- `cin`  in  1  carry in to bit 0.
- `out_valid`  out  1  `sum`/`co`/`ovf` hold a result.
- `out_ready`  in  1  consumer takes the result this cycle.
- `sum`  out  WIDTH  `(a + b + cin) mod 2^WIDTH`.
- `co`  out  1  carry out of bit WIDTH-1.
- `ovf`  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Stage k (0..STAGES-1) adds chunk k (`[k*CW +: CW]`) of A and B plus the carry registered by stage k-1. Stage 0 uses `cin`.
- Skew registers delay the not-yet-added upper chunks. Deskew registers carry the finished lower chunks forward. Each stage register holds a valid bit, partial sum, carry and remaining operand chunks.
- Global advance: `adv = !out_valid || out_ready`; `in_ready = adv`. When `adv` = 0 every stage register holds, including its valid bit. When `adv` = 1 every stage shifts forward by one. Stage 0 loads `in_valid` as its valid bit; if `in_valid` = 0 it loads a bubble.
- The final stage register drives `sum`, `co`, `ovf` and `out_valid`. Outputs are registered, with no combinational path from inputs.
- `ovf` uses the carry into bit WIDTH-1, computed inside the last chunk.
- Bubbles propagate; they do not collapse. Throughput is 1 result/cycle while `out_ready` = 1.
- Operand data entering with `in_valid` = 0 is don't-care and must not affect any valid result.

## Timing
- Reset (async assert, sync-deasserted externally): all stage valid bits = 0. `out_valid`=0, `sum`=0, `co`=0, `ovf`=0; `in_ready`=1 immediately after reset.
- Latency: a pair accepted on edge t (`in_valid && in_ready`) appears with `out_valid`=1 after edge t+STAGES-1. For STAGES=1 this is after the accepting edge itself.
- A result is consumed on the edge where `out_valid && out_ready`. With a result still held and `out_ready` = 0, `in_ready` drops in the same cycle and the operands on `a`/`b`/`cin` are not taken.
- While `out_valid` = 1 and `out_ready` = 0, `sum`/`co`/`ovf` must stay stable.
- Simultaneous accept and consume in one cycle is legal, and nothing is lost or duplicated.
- Reset mid-flight: all in-flight results are discarded and no stale `out_valid` appears after reset releases.
- Carry ripple per stage is limited to CW bits; the critical path is one CW-bit adder plus register setup.

## Test plan
Parameters WIDTH=16, STAGES=4 unless stated.
- Full ripple: `a`=0xFFFF, `b`=0x0001, `cin`=0 -> `sum`=0x0000, `co`=1, `ovf`=0, valid 3 edges after the accepting edge.
- Signed overflow: `a`=0x7FFF, `b`=0x0001, `cin`=0 -> 0x8000, `co`=0, `ovf`=1. Then `a`=0x8000, `b`=0x8000, `cin`=1 -> 0x0001, `co`=1, `ovf`=1.
- Streaming: 6 back-to-back pairs with `out_ready`=1 -> in-order results on 6 consecutive cycles, with `cin` honoured: 0x00F0+0x0010+1 = 0x0101; 0xFFFF+0xFFFF+1 = 0xFFFF with `co`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles while `in_valid`=1 -> `in_ready`=0 after the pipe fills, output stable, no drop or duplicate, order intact once `out_ready`=1.
- Reset mid-flight: assert `rst` with 3 results in flight -> `out_valid`=0 at once and stays 0 after release until a new accept.
- Random compare against `a+b+cin`, run at STAGES=1 and WIDTH=16, and at STAGES=16 and WIDTH=16.
